mi_nios_cpu_div_cell: RTL and testbench



---
 rtl/mi_nios_cpu_div_pkg.sv | 20 ++
 rtl/mi_nios_cpu_div_cell_if.sv | 26 ++
 rtl/mi_nios_cpu_div_step.sv | 22 ++
 rtl/mi_nios_cpu_div_cell.sv | 168 ++++++++++++++++
 tb/tb_mi_nios_cpu_div_cell.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mi_nios_cpu_div_pkg.sv
// Shared definitions for the Nios CPU divider cell: FSM states, default widths, divide-by-zero quotient.
package mi_nios_cpu_div_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_WIDTH  = 5;

  // Wide enough for any practical DATA_WIDTH; users slice the low bits.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic logic [DIV_DATA_WIDTH-1:0] div_mag(input logic sgn, input logic [DIV_DATA_WIDTH-1:0] x);
    return (sgn && x[DIV_DATA_WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mi_nios_cpu_div_cell_if.sv
// E-stage request / A-stage result bundle between the CPU pipeline and the divider cell.
interface mi_nios_cpu_div_cell_if
  import mi_nios_cpu_div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
);
  logic                  E_div_start;
  logic                  E_ctrl_div_signed;
  logic [DATA_WIDTH-1:0] E_src1_div_cell;
  logic [DATA_WIDTH-1:0] E_src2_div_cell;
  logic                  A_div_abort;
  logic                  A_div_busy;
  logic                  A_div_done;
  logic [DATA_WIDTH-1:0] A_div_quotient;
  logic [DATA_WIDTH-1:0] A_div_remainder;

  modport master (
    output E_div_start, E_ctrl_div_signed, E_src1_div_cell, E_src2_div_cell, A_div_abort,
    input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );

  modport slave (
    input  E_div_start, E_ctrl_div_signed, E_src1_div_cell, E_src2_div_cell, A_div_abort,
    output A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );
endinterface

// File: rtl/mi_nios_cpu_div_step.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract divisor, keep or restore.
module mi_nios_cpu_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] dvd,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_nxt,
  output logic [DATA_WIDTH-1:0] dvd_nxt,
  output logic                  qbit
);
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // One extra bit: the shifted remainder can exceed DATA_WIDTH bits before subtraction.
  assign shifted = {rem, dvd[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign qbit    = ~trial[DATA_WIDTH];
  assign rem_nxt = qbit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  // LSB left clear; the caller merges qbit so wider-radix variants can insert several bits.
  assign dvd_nxt = {dvd[DATA_WIDTH-2:0], 1'b0};
endmodule

// File: rtl/mi_nios_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios CPU, one quotient bit per clock.
// MI_NIOS_DIV_EARLY_OUT_EN: skip iteration when divisor is zero or |dividend| < |divisor|.
module mi_nios_cpu_div_cell
  import mi_nios_cpu_div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = DIV_CNT_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  mi_nios_cpu_div_cell_if.slave div
);

  div_state_e            state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic [DATA_WIDTH-1:0] rem, rem_n;
  logic [DATA_WIDTH-1:0] dvd, dvd_n;
  logic [DATA_WIDTH-1:0] dsr, dsr_n;
  logic [DATA_WIDTH-1:0] orig, orig_n;
  logic                  q_neg, q_neg_n;
  logic                  r_neg, r_neg_n;
  logic                  div0, div0_n;
  logic                  busy, busy_n;
  logic                  done, done_n;
  logic [DATA_WIDTH-1:0] quot, quot_n;
  logic [DATA_WIDTH-1:0] remo, remo_n;
`ifdef MI_NIOS_DIV_EARLY_OUT_EN
  logic                  eo, eo_n;
`endif

  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic [DATA_WIDTH-1:0] step_rem, step_dvd;
  logic                  step_qbit;

  assign mag1 = (div.E_ctrl_div_signed && div.E_src1_div_cell[DATA_WIDTH-1]) ?
                -div.E_src1_div_cell : div.E_src1_div_cell;
  assign mag2 = (div.E_ctrl_div_signed && div.E_src2_div_cell[DATA_WIDTH-1]) ?
                -div.E_src2_div_cell : div.E_src2_div_cell;

  mi_nios_cpu_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem     (rem),
    .dvd     (dvd),
    .divisor (dsr),
    .rem_nxt (step_rem),
    .dvd_nxt (step_dvd),
    .qbit    (step_qbit)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    dvd_n   = dvd;
    dsr_n   = dsr;
    orig_n  = orig;
    q_neg_n = q_neg;
    r_neg_n = r_neg;
    div0_n  = div0;
    busy_n  = busy;
    done_n  = 1'b0;
    quot_n  = quot;
    remo_n  = remo;
`ifdef MI_NIOS_DIV_EARLY_OUT_EN
    eo_n    = eo;
`endif
    if (div.A_div_abort) begin
      // Flush wins over a same-cycle start; result registers stay as they were.
      state_n = IDLE;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div.E_div_start) begin
            dvd_n   = mag1;
            dsr_n   = mag2;
            orig_n  = div.E_src1_div_cell;
            q_neg_n = div.E_ctrl_div_signed &
                      (div.E_src1_div_cell[DATA_WIDTH-1] ^ div.E_src2_div_cell[DATA_WIDTH-1]);
            r_neg_n = div.E_ctrl_div_signed & div.E_src1_div_cell[DATA_WIDTH-1];
            div0_n  = (div.E_src2_div_cell == '0);
            rem_n   = '0;
            cnt_n   = CNT_WIDTH'(DATA_WIDTH - 1);
            busy_n  = 1'b1;
            state_n = ITER;
`ifdef MI_NIOS_DIV_EARLY_OUT_EN
            eo_n    = 1'b0;
            if ((div.E_src2_div_cell == '0) || (mag1 < mag2)) begin
              eo_n    = 1'b1;
              state_n = FIX;
            end
`endif
          end
        end
        ITER: begin
          rem_n = step_rem;
          dvd_n = step_dvd | DATA_WIDTH'(step_qbit);
          if (cnt == '0) state_n = FIX;
          else           cnt_n   = cnt - 1'b1;
        end
        FIX: begin
          if (div0) begin
            // Divide by zero reports the dividend untouched, no sign fix.
            quot_n = DIV_ZERO_QUOT[DATA_WIDTH-1:0];
            remo_n = orig;
          end
`ifdef MI_NIOS_DIV_EARLY_OUT_EN
          else if (eo) begin
            quot_n = '0;
            remo_n = orig;
          end
`endif
          else begin
            quot_n = q_neg ? -dvd : dvd;
            remo_n = r_neg ? -rem : rem;
          end
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      orig  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      div0  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      remo  <= '0;
`ifdef MI_NIOS_DIV_EARLY_OUT_EN
      eo    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      dvd   <= dvd_n;
      dsr   <= dsr_n;
      orig  <= orig_n;
      q_neg <= q_neg_n;
      r_neg <= r_neg_n;
      div0  <= div0_n;
      busy  <= busy_n;
      done  <= done_n;
      quot  <= quot_n;
      remo  <= remo_n;
`ifdef MI_NIOS_DIV_EARLY_OUT_EN
      eo    <= eo_n;
`endif
    end
  end

  assign div.A_div_busy      = busy;
  assign div.A_div_done      = done;
  assign div.A_div_quotient  = quot;
  assign div.A_div_remainder = remo;

endmodule

// File: tb/tb_mi_nios_cpu_div_cell.sv
// Directed bench for mi_nios_cpu_div_cell: latency, signed/unsigned results, div0, abort, reset.
module tb_mi_nios_cpu_div_cell;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mi_nios_cpu_div_cell_if #(.DATA_WIDTH(32)) dif ();

  mi_nios_cpu_div_cell #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .div   (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    dif.E_div_start       = 1'b1;
    dif.E_ctrl_div_signed = sgn;
    dif.E_src1_div_cell   = a;
    dif.E_src2_div_cell   = b;
    tick();
    dif.E_div_start = 1'b0;
  endtask

  // e = edges after the start edge until done is seen; bc = cycles with busy high.
  task automatic wait_done(output int e, output int bc);
    e  = 0;
    bc = 0;
    while (dif.A_div_done !== 1'b1 && e < 200) begin
      if (dif.A_div_busy === 1'b1) bc++;
      tick();
      e++;
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er);
    int e, bc;
    issue(sgn, a, b);
    wait_done(e, bc);
    chk({tag, " lat"}, e, 33);
    chk({tag, " q"}, dif.A_div_quotient, eq);
    chk({tag, " r"}, dif.A_div_remainder, er);
  endtask

  initial begin
    int e, bc, nd;
    dif.E_div_start       = 1'b0;
    dif.E_ctrl_div_signed = 1'b0;
    dif.E_src1_div_cell   = '0;
    dif.E_src2_div_cell   = '0;
    dif.A_div_abort       = 1'b0;

    #1 reset = 1'b1;
    #1;
    chk("rst busy", dif.A_div_busy, 0);
    chk("rst done", dif.A_div_done, 0);
    chk("rst q", dif.A_div_quotient, 0);
    chk("rst r", dif.A_div_remainder, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 100/7 unsigned, full latency and busy window
    issue(1'b0, 32'd100, 32'd7);
    wait_done(e, bc);
    chk("u100/7 lat", e, 33);
    chk("u100/7 busycyc", bc, 33);
    chk("u100/7 busy@done", dif.A_div_busy, 0);
    chk("u100/7 q", dif.A_div_quotient, 32'd14);
    chk("u100/7 r", dif.A_div_remainder, 32'd2);

    // back-to-back start in the done cycle
    issue(1'b0, 32'hFFFF_FFFF, 32'h10);
    repeat (10) tick();
    chk("b2b hold q", dif.A_div_quotient, 32'd14);
    chk("b2b hold r", dif.A_div_remainder, 32'd2);
    wait_done(e, bc);
    chk("b2b lat", e + 10, 33);
    chk("b2b q", dif.A_div_quotient, 32'h0FFF_FFFF);
    chk("b2b r", dif.A_div_remainder, 32'hF);
    tick();

    run("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    tick();
    run("s100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    tick();
    run("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    tick();
    run("s div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    tick();
    run("u div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    tick();
    run("s-neg div0", 1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C);
    tick();

    // start while busy is dropped
    issue(1'b0, 32'd9, 32'd3);
    repeat (5) tick();
    issue(1'b0, 32'd100, 32'd7);
    wait_done(e, bc);
    chk("ign lat", e + 6, 33);
    chk("ign q", dif.A_div_quotient, 32'd3);
    chk("ign r", dif.A_div_remainder, 32'd0);
    tick();
    chk("ign noqueue busy", dif.A_div_busy, 0);

    // abort mid-iteration
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    dif.A_div_abort = 1'b1;
    tick();
    dif.A_div_abort = 1'b0;
    chk("abort busy", dif.A_div_busy, 0);
    chk("abort done", dif.A_div_done, 0);
    chk("abort q", dif.A_div_quotient, 32'd3);
    chk("abort r", dif.A_div_remainder, 32'd0);
    nd = 0;
    repeat (40) begin
      tick();
      if (dif.A_div_done === 1'b1) nd++;
    end
    chk("abort nodone", nd, 0);

    // abort beats a same-cycle start
    dif.A_div_abort = 1'b1;
    issue(1'b0, 32'd100, 32'd7);
    dif.A_div_abort = 1'b0;
    chk("abort+start busy", dif.A_div_busy, 0);
    nd = 0;
    repeat (40) begin
      tick();
      if (dif.A_div_done === 1'b1 || dif.A_div_busy === 1'b1) nd++;
    end
    chk("abort+start idle", nd, 0);

    // reset mid-ITER clears outputs at once
    issue(1'b0, 32'd100, 32'd7);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk("midrst busy", dif.A_div_busy, 0);
    chk("midrst done", dif.A_div_done, 0);
    chk("midrst q", dif.A_div_quotient, 0);
    chk("midrst r", dif.A_div_remainder, 0);
    tick();
    reset = 1'b0;
    tick();
    run("post-rst 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
